// File: rtl/rsnn_sequencer.sv
// rsnn_sequencer: loads neuron parameters over a byte stream and paces neuron updates while running.
// Optional feature macro RSNN_SPIKE_COUNT_EN builds the per-run spike counter and edge detector.
module rsnn_sequencer #(
  parameter logic [7:0] THR_RST   = 8'd64,
  parameter logic [7:0] DECAY_RST = 8'd4,
  parameter logic [7:0] REFR_RST  = 8'd3,
  parameter logic [7:0] FB_RST    = 8'd0,
  parameter logic [7:0] STEP_RST  = 8'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_start,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  input  logic       run_en,
  input  logic       spike_in,
  output logic       neuron_enable,
  output logic       neuron_clear,
  output logic [7:0] threshold,
  output logic [7:0] decay,
  output logic [7:0] refractory_period,
  output logic [7:0] feedback_scale,
  output logic [7:0] spike_count,
  output logic       busy,
  output logic [1:0] state
);

  // Handshake: a config byte transfers on every rising edge where cfg_valid && cfg_ready;
  // cfg_ready is high for the whole LOAD state and never depends on cfg_valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] byte_idx;
  logic [7:0] prescaler;
  logic [7:0] step_period;
  logic       clear_q;
  logic       cfg_accept;
  logic       run_entry;

  always_comb begin
    state_d       = state_q;
    cfg_ready     = 1'b0;
    neuron_enable = 1'b0;
    cfg_accept    = 1'b0;
    run_entry     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
        end else if (run_en) begin
          state_d   = RUN;
          run_entry = 1'b1;
        end
      end
      LOAD: begin
        cfg_ready  = 1'b1;
        cfg_accept = cfg_valid;
        if (cfg_valid && byte_idx == 3'd4) state_d = IDLE;
      end
      RUN: begin
        // The exit cycle (run_en low) never strobes the neuron.
        if (!run_en) state_d = IDLE;
        else         neuron_enable = (prescaler == step_period);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      byte_idx          <= 3'd0;
      prescaler         <= 8'd0;
      clear_q           <= 1'b0;
      threshold         <= THR_RST;
      decay             <= DECAY_RST;
      refractory_period <= REFR_RST;
      feedback_scale    <= FB_RST;
      step_period       <= STEP_RST;
    end else begin
      state_q <= state_d;
      clear_q <= run_entry;
      if (cfg_accept) begin
        byte_idx <= (byte_idx == 3'd4) ? 3'd0 : byte_idx + 3'd1;
        case (byte_idx)
          3'd0:    threshold         <= cfg_data;
          3'd1:    decay             <= cfg_data;
          3'd2:    refractory_period <= cfg_data;
          3'd3:    feedback_scale    <= cfg_data;
          3'd4:    step_period       <= cfg_data;
          default: ;
        endcase
      end else if (state_q != LOAD) begin
        byte_idx <= 3'd0;
      end
      if (state_q == RUN && run_en) prescaler <= neuron_enable ? 8'd0 : prescaler + 8'd1;
      else                          prescaler <= 8'd0;
    end
  end

  assign neuron_clear = clear_q;
  assign busy         = (state_q != IDLE);
  assign state        = state_q;

`ifdef RSNN_SPIKE_COUNT_EN
  logic       spike_prev;
  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_prev <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      spike_prev <= spike_in;
      if (run_entry) begin
        count_q <= 8'd0;
      end else if (state_q == RUN && spike_in && !spike_prev && count_q != 8'hFF) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign spike_count = count_q;
`else
  logic unused_spike_in;
  assign unused_spike_in = spike_in;
  assign spike_count     = 8'd0;
`endif

endmodule

// File: tb/tb_rsnn_sequencer.sv
// tb_rsnn_sequencer: directed plus randomized stimulus against a cycle-level behavioural model.
module tb_rsnn_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cfg_start;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       run_en;
  logic       spike_in;
  logic       neuron_enable;
  logic       neuron_clear;
  logic [7:0] threshold;
  logic [7:0] decay;
  logic [7:0] refractory_period;
  logic [7:0] feedback_scale;
  logic [7:0] spike_count;
  logic       busy;
  logic [1:0] state;

  rsnn_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_start         (cfg_start),
    .cfg_valid         (cfg_valid),
    .cfg_data          (cfg_data),
    .cfg_ready         (cfg_ready),
    .run_en            (run_en),
    .spike_in          (spike_in),
    .neuron_enable     (neuron_enable),
    .neuron_clear      (neuron_clear),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .feedback_scale    (feedback_scale),
    .spike_count       (spike_count),
    .busy              (busy),
    .state             (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int en_seen  = 0;
  int clr_seen = 0;

  // Behavioural model: mode, load index, cycles since RUN entry, spike total
  int         m_state;
  int         m_idx;
  int         m_age;
  int         m_count;
  logic       m_prev;
  logic [7:0] m_cfg[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_idx   = 0;
    m_age   = 0;
    m_count = 0;
    m_prev  = 1'b0;
    m_cfg   = '{8'd64, 8'd4, 8'd3, 8'd0, 8'd9};
  endtask

  task automatic check_outputs();
    int sp;
    logic e_en;
    logic [7:0] e_cnt;
    sp   = int'(m_cfg[4]);
    e_en = (m_state == 2) && run_en && ((m_age % (sp + 1)) == sp);
`ifdef RSNN_SPIKE_COUNT_EN
    e_cnt = m_count[7:0];
`else
    e_cnt = 8'd0;
`endif
    chk("state", 32'(state), 32'(m_state));
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_state == 1));
    chk("neuron_enable", 32'(neuron_enable), 32'(e_en));
    chk("neuron_clear", 32'(neuron_clear), 32'((m_state == 2) && (m_age == 0)));
    chk("threshold", 32'(threshold), 32'(m_cfg[0]));
    chk("decay", 32'(decay), 32'(m_cfg[1]));
    chk("refractory_period", 32'(refractory_period), 32'(m_cfg[2]));
    chk("feedback_scale", 32'(feedback_scale), 32'(m_cfg[3]));
    chk("spike_count", 32'(spike_count), 32'(e_cnt));
    if (neuron_enable === 1'b1) en_seen++;
    if (neuron_clear === 1'b1) clr_seen++;
  endtask

  task automatic model_step();
    case (m_state)
      0: begin
        if (cfg_start) begin
          m_state = 1;
          m_idx   = 0;
        end else if (run_en) begin
          m_state = 2;
          m_age   = 0;
          m_count = 0;
        end
      end
      1: begin
        if (cfg_valid) begin
          m_cfg[m_idx] = cfg_data;
          if (m_idx == 4) begin
            m_state = 0;
            m_idx   = 0;
          end else begin
            m_idx++;
          end
        end
      end
      default: begin
        if (spike_in && !m_prev && m_count < 255) m_count++;
        if (!run_en) m_state = 0;
        else         m_age++;
      end
    endcase
    m_prev = spike_in;
  endtask

  // Driver: apply inputs after the falling edge, check, then advance the model on the rising edge
  task automatic cyc(input logic cs, input logic re, input logic cv, input logic [7:0] cd,
                     input logic sp);
    @(negedge clk);
    cfg_start = cs;
    run_en    = re;
    cfg_valid = cv;
    cfg_data  = cd;
    spike_in  = sp;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    cfg_start = 1'b0;
    run_en    = 1'b0;
    cfg_valid = 1'b0;
    spike_in  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_random();
    logic [7:0] d;
    cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'd0, 1'b0);
    for (int b = 0; b < 5; b++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'($urandom),
            1'($urandom_range(0, 1)));
      d = (b == 4) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, d, 1'($urandom_range(0, 1)));
    end
    idle(2);
  endtask

  task automatic run_random(input int len);
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < len; i++) cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'($urandom_range(0, 1)));
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    idle(2);
  endtask

  logic [7:0] load_bytes[5];

  initial begin
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    run_en    = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 8'd0;
    spike_in  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values with no stimulus
    idle(3);

    // Gapped configuration load
    load_bytes = '{8'd100, 8'd2, 8'd5, 8'hF0, 8'd3};
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    for (int b = 0; b < 5; b++) begin
      cyc(1'b0, 1'b0, 1'b1, load_bytes[b], 1'b0);
      if (b < 4) cyc(1'b0, 1'b0, 1'b0, 8'hAA, 1'b0);
    end
    idle(2);
    chk("load_thr", 32'(threshold), 32'd100);
    chk("load_fb", 32'(feedback_scale), 32'hF0);

    // Run twelve cycles with step_period 3, then drop run_en
    en_seen  = 0;
    clr_seen = 0;
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    for (int c = 1; c <= 12; c++) cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    idle(4);
    chk("run_enable_total", 32'(en_seen), 32'd3);
    chk("run_clear_total", 32'(clr_seen), 32'd1);

    // 300 three-cycle spike bursts drive the counter into saturation
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
      for (int g = 0; g < int'($urandom_range(1, 2)); g++) cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    idle(3);
`ifdef RSNN_SPIKE_COUNT_EN
    chk("spike_saturated", 32'(spike_count), 32'd255);
`else
    chk("spike_disabled", 32'(spike_count), 32'd0);
`endif
    run_random(3);

    // Randomized loads and runs; the counter must hold through LOAD
    for (int it = 0; it < 6; it++) begin
      load_random();
      run_random(int'($urandom_range(3, 30)));
    end

    // Reset in the middle of a run
    cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    async_reset();
    idle(2);

    // cfg_start beats run_en, then reset after two bytes
    cyc(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'd17, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 8'd33, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    async_reset();
    chk("abort_thr", 32'(threshold), 32'd64);
    chk("abort_decay", 32'(decay), 32'd4);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
